// File: rtl/pri_8to3.sv
// Registered 8-input priority encoder: highest-numbered set bit of x -> y, any-bit-set -> Valid.
// Outputs update one clock after x is sampled; synchronous active-low reset clears both.
module pri_8to3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] x,
  output logic [2:0] y,
  output logic       Valid
);

  logic [2:0] y_d;
  logic [2:0] y_q;
  logic       valid_d;
  logic       valid_q;

  // Priority scan from bit 7 down; an empty vector encodes as index 0 with valid low.
  always_comb begin
    y_d     = 3'd0;
    valid_d = |x;
    casez (x)
      8'b1???_????: y_d = 3'd7;
      8'b01??_????: y_d = 3'd6;
      8'b001?_????: y_d = 3'd5;
      8'b0001_????: y_d = 3'd4;
      8'b0000_1???: y_d = 3'd3;
      8'b0000_01??: y_d = 3'd2;
      8'b0000_001?: y_d = 3'd1;
      8'b0000_0001: y_d = 3'd0;
      default:      y_d = 3'd0;
    endcase
  end

  // Output registers; reset wins over the encode at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_pri_8to3.sv
// Self-checking bench for pri_8to3: directed vector table, reset sequences,
// exhaustive down-count sweep and randomized traffic against a reference model.
module tb_pri_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] x;
  logic [2:0] y;
  logic       Valid;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] x;
    logic [2:0] y;
    logic       v;
  } vec_t;

  vec_t vecs[$];

  pri_8to3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .Valid (Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the highest set bit by repeated halving; valid when nonzero.
  function automatic void ref_model(input logic [7:0] xv, output logic [2:0] yv, output logic vv);
    int idx;
    int t;
    idx = 0;
    t   = int'(xv);
    while (t > 1) begin
      t   = t / 2;
      idx = idx + 1;
    end
    yv = idx[2:0];
    vv = (xv != 8'h00);
  endfunction

  task automatic check(input string name, input logic [2:0] exp_y, input logic exp_v);
    checks = checks + 1;
    if (y !== exp_y || Valid !== exp_v) begin
      failures = failures + 1;
      $display("FAIL %s: got y=%0d Valid=%0b, expected y=%0d Valid=%0b", name, y, Valid, exp_y, exp_v);
    end
  endtask

  // Apply inputs away from the edge, take one rising edge, settle.
  task automatic step(input logic [7:0] xv, input logic rv);
    x     = xv;
    rst_n = rv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] ey;
    logic       ev;
    checks   = 0;
    failures = 0;
    x        = 8'hFF;
    rst_n    = 1'b0;
    #2;

    // Reset held two edges with all requests set, then released.
    step(8'hFF, 1'b0);
    check("reset_1", 3'd0, 1'b0);
    step(8'hFF, 1'b0);
    check("reset_2", 3'd0, 1'b0);
    step(8'hFF, 1'b1);
    check("reset_release", 3'd7, 1'b1);

    // Directed vectors: one-hot walk, priority masking, empty vs bit 0.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.x = 8'h01 << i;
      v.y = 3'(i);
      v.v = 1'b1;
      vecs.push_back(v);
    end
    vecs.push_back('{8'h81, 3'd7, 1'b1});
    vecs.push_back('{8'h7F, 3'd6, 1'b1});
    vecs.push_back('{8'h0C, 3'd3, 1'b1});
    vecs.push_back('{8'h03, 3'd1, 1'b1});
    vecs.push_back('{8'h00, 3'd0, 1'b0});
    vecs.push_back('{8'h01, 3'd0, 1'b1});
    vecs.push_back('{8'h00, 3'd0, 1'b0});
    vecs.push_back('{8'h55, 3'd6, 1'b1});
    foreach (vecs[i]) begin
      step(vecs[i].x, 1'b1);
      check($sformatf("table_%0d_x%02h", i, vecs[i].x), vecs[i].y, vecs[i].v);
    end

    // Input changes between edges must not reach the registered outputs.
    step(8'h10, 1'b1);
    x = 8'h80;
    #3;
    check("hold_between_edges", 3'd4, 1'b1);
    @(posedge clk);
    #1;
    check("after_hold_edge", 3'd7, 1'b1);

    // Exhaustive down-count sweep with a one-edge reset in the middle.
    for (int v = 255; v >= 0; v--) begin
      logic [7:0] xv;
      xv = 8'(v);
      if (v == 8'h50) begin
        step(xv, 1'b0);
        check("sweep_midreset", 3'd0, 1'b0);
      end else begin
        step(xv, 1'b1);
        ref_model(xv, ey, ev);
        check($sformatf("sweep_x%02h", xv), ey, ev);
      end
    end

    // Randomized traffic with sporadic resets.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] xv;
      logic       rv;
      xv = 8'($urandom_range(0, 255));
      rv = ($urandom_range(0, 15) != 0);
      step(xv, rv);
      if (rv) begin
        ref_model(xv, ey, ev);
      end else begin
        ey = 3'd0;
        ev = 1'b0;
      end
      check($sformatf("rand_%0d_x%02h_r%0b", n, xv, rv), ey, ev);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
